result_uart_tx: RTL

Serial transmitter that returns SAD match results to the host over the same UART link that delivers image data. It sits beside the processing core and is triggered by the core's valid pulse. It captures match status and coordinates, frames them as a fixed binary packet, and shifts it out 8N1 on TxD. Its done pulse is the send-complete acknowledge back to the core.

---
 rtl/result_uart_tx.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/result_uart_tx.sv
// Result packet transmitter: captures match/x/y on send and shifts a 6-byte
// (7 with CHECKSUM_EN) sync-prefixed packet out as 8N1 serial on TxD.
`timescale 1ns/1ps

module result_uart_tx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send,
    input  logic       match,
    input  logic [9:0] x_in,
    input  logic [8:0] y_in,
    output logic       busy,
    output logic       done,
    output logic       TxD
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);

`ifdef CHECKSUM_EN
    localparam int NBYTES = 7;
`else
    localparam int NBYTES = 6;
`endif
    localparam logic [2:0] LAST_BYTE = 3'(NBYTES - 1);
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [2:0]       byte_idx_q, byte_idx_d;
    logic             match_q, match_d;
    logic [9:0]       x_q, x_d;
    logic [8:0]       y_q, y_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [7:0] cur_byte;
    logic       baud_end;

`ifdef CHECKSUM_EN
    logic [7:0] checksum;
    assign checksum = SYNC_BYTE ^ {7'b0, match_q} ^ {6'b0, x_q[9:8]} ^ x_q[7:0]
                    ^ {7'b0, y_q[8]} ^ y_q[7:0];
`endif

    // Byte currently on the wire, selected from the captured packet fields.
    always_comb begin
        cur_byte = SYNC_BYTE;
        case (byte_idx_q)
            3'd0:    cur_byte = SYNC_BYTE;
            3'd1:    cur_byte = {7'b0, match_q};
            3'd2:    cur_byte = {6'b0, x_q[9:8]};
            3'd3:    cur_byte = x_q[7:0];
            3'd4:    cur_byte = {7'b0, y_q[8]};
            3'd5:    cur_byte = y_q[7:0];
`ifdef CHECKSUM_EN
            3'd6:    cur_byte = checksum;
`endif
            default: cur_byte = SYNC_BYTE;
        endcase
    end

    assign baud_end = (baud_cnt_q == BAUD_LAST);

    // NOTE: every variable gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        match_d    = match_q;
        x_d        = x_q;
        y_d        = y_q;
        shift_d    = shift_q;
        txd_d      = txd_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (send) begin
                    state_d    = S_START;
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    byte_idx_d = '0;
                    match_d    = match;
                    x_d        = x_in;
                    y_d        = y_in;
                    txd_d      = 1'b0;
                    busy_d     = 1'b1;
                end
            end

            S_START: begin
                if (baud_end) begin
                    baud_cnt_d = '0;
                    state_d    = S_DATA;
                    txd_d      = cur_byte[0];
                    shift_d    = {1'b0, cur_byte[7:1]};
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_ONE;
                end
            end

            S_DATA: begin
                if (baud_end) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d   = S_STOP;
                        bit_cnt_d = '0;
                        txd_d     = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        txd_d     = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_ONE;
                end
            end

            S_STOP: begin
                if (baud_end) begin
                    baud_cnt_d = '0;
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d    = S_IDLE;
                        byte_idx_d = '0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        state_d    = S_START;
                        byte_idx_d = byte_idx_q + 3'd1;
                        txd_d      = 1'b0;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: non-blocking updates so every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
            match_q    <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            match_q    <= match_d;
            x_q        <= x_d;
            y_q        <= y_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign TxD  = txd_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
